pcie_bram_fifo_ctrl: RTL and testbench
======================================

PCIE_BRAM_FIFO_CTRL -- requirements
Module: pcie_bram_fifo_ctrl

Interface
REQ-001 Parameter DEPTH, default 11, number of RAM address bits used (2**DEPTH entries).
REQ-002 Parameter DW, default 72, data width.
REQ-003 user_clk_i  in  1  sole clock; all logic on rising edge.
REQ-004 reset_n_i  in  1  reset, asynchronous assert, active-low.
REQ-005 flush_i  in  1  synchronous clear of all stored and in-flight data.
REQ-006 in_valid_i / in_ready_o / in_data_i  in/out/in  1/1/DW  write stream, transfer when valid&ready.
REQ-007 out_valid_o / out_ready_i / out_data_o  out/in/out  1/1/DW  read stream, transfer when valid&ready.
REQ-008 ram_wen_o / ram_waddr_o / ram_wdata_o  out  1/13/DW  RAM write port, driven from the write stream.
REQ-009 ram_ren_o / ram_rce_o / ram_raddr_o  out  1/1/13  RAM read request.
REQ-010 ram_rdata_i  in  DW  RAM read data, valid exactly 2 cycles after the cycle ram_ren_o was sampled high.
REQ-011 level_o  out  DEPTH+1  entries held in RAM (excludes output buffer and in-flight reads).

Function
REQ-012 Write and read pointers SHALL be DEPTH+1 bits; address = low DEPTH bits zero-extended to 13; wrap modulo 2**DEPTH.
REQ-013 full = pointers differ only in MSB; empty = pointers equal.
REQ-014 in_ready_o SHALL be !full & !flush_i; an input handshake SHALL assert ram_wen_o in the same cycle with ram_waddr_o = wptr, ram_wdata_o = in_data_i, and increment wptr.
REQ-015 ram_rce_o SHALL be constant 1.
REQ-016 ram_ren_o SHALL assert when RAM not empty, not flush_i, and (in-flight reads + output buffer occupancy) < 4; ram_raddr_o = rptr; rptr increments on each issued read.
REQ-017 A 2-stage valid shift register SHALL track in-flight reads; when its tail is set, ram_rdata_i SHALL be pushed into a 4-entry output buffer that same cycle.
REQ-018 Output buffer SHALL never overflow by construction of REQ-016; out_valid_o = buffer non-empty; out_data_o = buffer head, held stable while out_valid_o & !out_ready_i.
REQ-019 Timing: input handshake at edge T -> ram_ren_o sampled at T+1 earliest -> data in buffer at T+3 -> out_valid_o high from T+3.
REQ-020 Sustained throughput SHALL be 1 word/cycle when in_valid_i and out_ready_i held high.
REQ-021 Simultaneous write and read issue SHALL be legal; level_o unchanged in that case.
REQ-022 A write is visible to a read issued on the next cycle or later; reads never target an uncommitted slot, so no read/write collision occurs.
REQ-023 flush_i SHALL, at the next edge, set wptr = rptr = 0, clear buffer and in-flight valids; RAM data returning afterwards SHALL be discarded; no handshake occurs in the flush cycle (in_ready_o = 0, out_valid_o may be high but pop ignored).
REQ-024 level_o = wptr - rptr, DEPTH+1 bits, registered.

Reset
REQ-025 On reset_n_i low: pointers 0, in-flight valids 0, buffer empty; out_valid_o 0, ram_wen_o 0, ram_ren_o 0, level_o 0, in_ready_o 0 while reset asserted, out_data_o 0.
REQ-026 Reset deassertion SHALL be synchronised externally; the block SHALL accept input on the first edge after release.
REQ-027 Reset mid-operation SHALL discard all data including in-flight reads.

Structure
REQ-028 Shared package pcie_bram_pkg SHALL hold DW, RAM address width 13, read latency 2, output buffer depth 4.
REQ-029 The output buffer SHALL be sub-module pcie_skid_fifo4 (register FIFO, push/pop/count, async active-low reset).
REQ-030 RAM itself is external; this block contains no storage array beyond the 4-entry buffer.

Verification
REQ-031 Single word 0xA5 written at edge T, out_ready_i=1 -> ram_ren_o at T+1, out_valid_o high from T+3 with data 0xA5, level_o back to 0.
REQ-032 Write 2048 words (DEPTH=11) with out_ready_i=0 -> after buffer fills 4 and RAM holds 2044, continue until in_ready_o=0 at level_o=2048; no ram_wen_o when full.
REQ-033 Stream 5000 incrementing words, both sides always ready -> output in order, 1 word/cycle after fill, pointer wrap exercised twice.
REQ-034 Random in_valid_i / out_ready_i 10000 words -> scoreboard matches, no buffer overflow, ram_ren_o never with level_o=0.
REQ-035 flush_i pulsed one cycle after two reads issued -> stale returns dropped, out_valid_o 0, level_o 0, next written word 0x1 emerges first.
REQ-036 reset_n_i asserted with 10 words stored and 2 in flight -> all outputs at reset values immediately, no stale word after release.

Source files
------------

// File: rtl/pcie_bram_pkg.sv
// Shared constants for the BRAM-backed stream FIFO controller: data width,
// external RAM address width, RAM read latency and output buffer sizing.
package pcie_bram_pkg;

    localparam int DW         = 72;                       // default stream / RAM data width
    localparam int RAM_AW     = 13;                       // external RAM address width
    localparam int RD_LAT     = 2;                        // RAM read latency in cycles
    localparam int OBUF_DEPTH = 4;                        // output buffer entries
    localparam int OBUF_IDX_W = $clog2(OBUF_DEPTH);       // output buffer index width
    localparam int OBUF_CNT_W = $clog2(OBUF_DEPTH + 1);   // output buffer count width

    // A read may only be issued if every word already on its way back
    // (in flight or parked in the buffer) still leaves room for it.
    function automatic logic read_credit_ok(input logic [RD_LAT-1:0]     inflight,
                                            input logic [OBUF_CNT_W-1:0] buf_count);
        return ($countones(inflight) + int'(buf_count)) < OBUF_DEPTH;
    endfunction

endpackage

// File: rtl/pcie_bram_fifo_ctrl_if.sv
// Write and read stream handshakes of the BRAM FIFO controller. Signal
// suffixes are named from the controller's point of view.
interface pcie_bram_fifo_ctrl_if #(
    parameter int DW = pcie_bram_pkg::DW
);

    logic          in_valid_i;
    logic          in_ready_o;
    logic [DW-1:0] in_data_i;
    logic          out_valid_o;
    logic          out_ready_i;
    logic [DW-1:0] out_data_o;

    // Controller side.
    modport slave (
        input  in_valid_i, in_data_i, out_ready_i,
        output in_ready_o, out_valid_o, out_data_o
    );

    // Producer / consumer side.
    modport master (
        output in_valid_i, in_data_i, out_ready_i,
        input  in_ready_o, out_valid_o, out_data_o
    );

endinterface

// File: rtl/pcie_skid_fifo4.sv
// Small register FIFO that catches RAM read returns. The head entry is
// presented combinationally and stays put until popped.
module pcie_skid_fifo4 #(
    parameter int DW = pcie_bram_pkg::DW
) (
    input  logic                              clk,
    input  logic                              rst_n,
    input  logic                              flush,
    input  logic                              push,
    input  logic [DW-1:0]                     push_data,
    input  logic                              pop,
    output logic [DW-1:0]                     head_data,
    output logic                              empty,
    output logic [pcie_bram_pkg::OBUF_CNT_W-1:0] count
);

    import pcie_bram_pkg::*;

    typedef logic [OBUF_IDX_W-1:0] idx_t;
    typedef logic [OBUF_CNT_W-1:0] cnt_t;

    logic [DW-1:0] mem_q [OBUF_DEPTH];
    logic [DW-1:0] mem_d [OBUF_DEPTH];
    idx_t          wr_idx_q, wr_idx_d;
    idx_t          rd_idx_q, rd_idx_d;
    cnt_t          count_q,  count_d;
    logic          do_pop;

    // Popping an empty buffer is ignored so the caller need not gate it.
    assign do_pop = pop && (count_q != '0);

    // Next-state for storage, indices and occupancy; flush wins over push/pop.
    always_comb begin
        // NOTE: every variable gets a default first so no path leaves it unassigned (no latch).
        mem_d    = mem_q;
        wr_idx_d = wr_idx_q;
        rd_idx_d = rd_idx_q;
        count_d  = count_q;
        if (flush) begin
            wr_idx_d = '0;
            rd_idx_d = '0;
            count_d  = '0;
        end else begin
            if (push) begin
                mem_d[wr_idx_q] = push_data;
                wr_idx_d        = wr_idx_q + idx_t'(1);
            end
            if (do_pop) begin
                rd_idx_d = rd_idx_q + idx_t'(1);
            end
            count_d = count_q + cnt_t'(push) - cnt_t'(do_pop);
        end
    end

    // Register storage and bookkeeping.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            // NOTE: the storage is reset too (only four words) so the head reads 0 out of reset.
            mem_q    <= '{default: '0};
            wr_idx_q <= '0;
            rd_idx_q <= '0;
            count_q  <= '0;
        end else begin
            // NOTE: state updates use non-blocking assignments so every flop samples pre-edge values.
            mem_q    <= mem_d;
            wr_idx_q <= wr_idx_d;
            rd_idx_q <= rd_idx_d;
            count_q  <= count_d;
        end
    end

    assign head_data = mem_q[rd_idx_q];
    assign empty     = (count_q == '0);
    assign count     = count_q;

endmodule

// File: rtl/pcie_bram_fifo_ctrl.sv
// Stream FIFO controller in front of an external simple dual-port BRAM.
// Writes go straight to the RAM; reads are pre-fetched with a 2-cycle RAM
// latency into a 4-entry output buffer, which gives 1 word/cycle throughput.
module pcie_bram_fifo_ctrl #(
    parameter int DEPTH = 11,
    parameter int DW    = pcie_bram_pkg::DW
) (
    input  logic                              user_clk_i,
    input  logic                              reset_n_i,
    input  logic                              flush_i,
    pcie_bram_fifo_ctrl_if.slave              stream,
    output logic                              ram_wen_o,
    output logic [pcie_bram_pkg::RAM_AW-1:0]  ram_waddr_o,
    output logic [DW-1:0]                     ram_wdata_o,
    output logic                              ram_ren_o,
    output logic                              ram_rce_o,
    output logic [pcie_bram_pkg::RAM_AW-1:0]  ram_raddr_o,
    input  logic [DW-1:0]                     ram_rdata_i,
    output logic [DEPTH:0]                    level_o
);

    import pcie_bram_pkg::*;

    // One extra pointer bit tells full from empty when the addresses match.
    typedef logic [DEPTH:0] ptr_t;

    ptr_t                  wptr_q, wptr_d;
    ptr_t                  rptr_q, rptr_d;
    ptr_t                  level_q, level_d;
    logic [RD_LAT-1:0]     inflight_q, inflight_d;

    logic                  ram_full;
    logic                  ram_empty;
    logic                  in_ready;
    logic                  wr_fire;
    logic                  rd_issue;
    logic                  rd_return;
    logic                  out_pop;
    logic                  obuf_empty;
    logic [OBUF_CNT_W-1:0] obuf_count;
    logic [DW-1:0]         obuf_head;

    // Pointer status, handshakes and read-issue decision.
    always_comb begin
        ram_full  = (wptr_q[DEPTH] != rptr_q[DEPTH]) &&
                    (wptr_q[DEPTH-1:0] == rptr_q[DEPTH-1:0]);
        ram_empty = (wptr_q == rptr_q);
        // reset_n_i keeps ready low for the whole time reset is held.
        in_ready  = !ram_full && !flush_i && reset_n_i;
        wr_fire   = stream.in_valid_i && in_ready;
        rd_issue  = !ram_empty && !flush_i && read_credit_ok(inflight_q, obuf_count);
        rd_return = inflight_q[RD_LAT-1];
        out_pop   = stream.out_ready_i && !obuf_empty && !flush_i;
    end

    // Next-state for pointers, in-flight tracker and level.
    always_comb begin
        wptr_d     = wptr_q;
        rptr_d     = rptr_q;
        inflight_d = {inflight_q[RD_LAT-2:0], rd_issue};
        if (flush_i) begin
            // Dropping the in-flight valids discards any RAM data still on its way.
            wptr_d     = '0;
            rptr_d     = '0;
            inflight_d = '0;
        end else begin
            if (wr_fire) begin
                wptr_d = wptr_q + ptr_t'(1);
            end
            if (rd_issue) begin
                rptr_d = rptr_q + ptr_t'(1);
            end
        end
        level_d = wptr_d - rptr_d;
    end

    // Register pointers, in-flight tracker and the level output.
    always_ff @(posedge user_clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            wptr_q     <= '0;
            rptr_q     <= '0;
            inflight_q <= '0;
            level_q    <= '0;
        end else begin
            wptr_q     <= wptr_d;
            rptr_q     <= rptr_d;
            inflight_q <= inflight_d;
            level_q    <= level_d;
        end
    end

    // Returned words land in the output buffer the cycle the tracker tail is set.
    pcie_skid_fifo4 #(
        .DW (DW)
    ) u_obuf (
        .clk       (user_clk_i),
        .rst_n     (reset_n_i),
        .flush     (flush_i),
        .push      (rd_return),
        .push_data (ram_rdata_i),
        .pop       (out_pop),
        .head_data (obuf_head),
        .empty     (obuf_empty),
        .count     (obuf_count)
    );

    // RAM ports: addresses are the low pointer bits, zero-extended.
    assign ram_wen_o   = wr_fire;
    assign ram_waddr_o = RAM_AW'(wptr_q[DEPTH-1:0]);
    assign ram_wdata_o = stream.in_data_i;
    assign ram_ren_o   = rd_issue;
    assign ram_rce_o   = 1'b1;
    assign ram_raddr_o = RAM_AW'(rptr_q[DEPTH-1:0]);

    // Stream side.
    assign stream.in_ready_o  = in_ready;
    assign stream.out_valid_o = !obuf_empty;
    assign stream.out_data_o  = obuf_head;
    assign level_o            = level_q;

endmodule

// File: tb/tb_pcie_bram_fifo_ctrl.sv
// Self-checking bench for pcie_bram_fifo_ctrl: a behavioural RAM with a
// 2-cycle read latency, a word-queue reference model fed by a monitor, and
// directed plus random stimulus.
module tb_pcie_bram_fifo_ctrl;

    import pcie_bram_pkg::*;

    localparam int DEPTH   = 11;
    localparam int ENTRIES = 1 << DEPTH;

    logic                user_clk = 1'b0;
    logic                reset_n  = 1'b0;
    logic                flush    = 1'b0;
    logic                ram_wen, ram_ren, ram_rce;
    logic [RAM_AW-1:0]   ram_waddr, ram_raddr;
    logic [DW-1:0]       ram_wdata, ram_rdata;
    logic [DEPTH:0]      level;

    pcie_bram_fifo_ctrl_if #(.DW(DW)) stream_if ();

    pcie_bram_fifo_ctrl #(
        .DEPTH (DEPTH),
        .DW    (DW)
    ) dut (
        .user_clk_i  (user_clk),
        .reset_n_i   (reset_n),
        .flush_i     (flush),
        .stream      (stream_if),
        .ram_wen_o   (ram_wen),
        .ram_waddr_o (ram_waddr),
        .ram_wdata_o (ram_wdata),
        .ram_ren_o   (ram_ren),
        .ram_rce_o   (ram_rce),
        .ram_raddr_o (ram_raddr),
        .ram_rdata_i (ram_rdata),
        .level_o     (level)
    );

    always #5 user_clk = ~user_clk;

    // Behavioural external RAM: data of a read sampled at edge E is valid
    // during the cycle that ends with edge E+2.
    logic [DW-1:0] ram_mem [1 << RAM_AW];
    logic [DW-1:0] rd_pipe [RD_LAT];

    always @(posedge user_clk) begin
        if (ram_wen) ram_mem[ram_waddr] <= ram_wdata;
        rd_pipe[0] <= ram_mem[ram_raddr];
        for (int i = 1; i < RD_LAT; i++) rd_pipe[i] <= rd_pipe[i-1];
    end
    assign ram_rdata = rd_pipe[RD_LAT-1];

    // Reference model: the words accepted and not yet delivered, in order.
    logic [DW-1:0] model_q [$];
    int n_checks = 0;
    int n_errors = 0;
    int cyc      = 0;
    int n_pop    = 0;
    int first_pop_cyc = -1;
    int last_pop_cyc  = -1;

    always @(posedge user_clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [127:0] actual, input logic [127:0] expected);
        n_checks++;
        if (actual !== expected) begin
            n_errors++;
            $display("FAIL %s at cycle %0d: got %0h, want %0h", name, cyc, actual, expected);
        end
    endtask

    // Monitor: sample every handshake mid-cycle, update and compare against the model.
    always @(negedge user_clk) begin
        if (!reset_n) begin
            model_q.delete();
        end else if (flush) begin
            check("flush_in_ready", stream_if.in_ready_o, 1'b0);
            model_q.delete();
        end else begin
            if (ram_ren) check("ren_with_level", level != '0, 1'b1);
            if (stream_if.in_valid_i && stream_if.in_ready_o) model_q.push_back(stream_if.in_data_i);
            if (stream_if.out_valid_o && stream_if.out_ready_i) begin
                if (model_q.size() == 0) begin
                    n_checks++;
                    n_errors++;
                    $display("FAIL unexpected_output at cycle %0d: got %0h, want no word", cyc, stream_if.out_data_o);
                end else begin
                    check("out_data", stream_if.out_data_o, model_q.pop_front());
                end
                n_pop++;
                if (first_pop_cyc < 0) first_pop_cyc = cyc;
                last_pop_cyc = cyc;
            end
        end
    end

    task automatic tick();
        @(posedge user_clk);
        #1;
    endtask

    // One clock of stimulus; acc reports whether the write was taken.
    task automatic cycle(input logic v, input logic [DW-1:0] d, input logic r, output logic acc);
        stream_if.in_valid_i  = v;
        stream_if.in_data_i   = d;
        stream_if.out_ready_i = r;
        @(negedge user_clk);
        acc = v && stream_if.in_ready_o;
        tick();
    endtask

    function automatic logic [DW-1:0] rand_word();
        return DW'({$urandom(), $urandom(), $urandom()});
    endfunction

    // Pull everything out; a bound that expires counts as a failed check.
    task automatic drain(input string name, input int max_cycles);
        logic acc;
        bit   done;
        done = 1'b0;
        for (int i = 0; i < max_cycles && !done; i++) begin
            if (model_q.size() == 0 && !stream_if.out_valid_o) done = 1'b1;
            else cycle(1'b0, '0, 1'b1, acc);
        end
        check(name, done, 1'b1);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout, want completion");
        $fatal(1, "bench did not complete in time");
    end

    initial begin
        logic acc;
        int   accepted;
        int   sent;
        bit   seen;

        stream_if.in_valid_i  = 1'b1;
        stream_if.in_data_i   = DW'(8'h5A);
        stream_if.out_ready_i = 1'b1;
        #2;
        check("rst_out_valid", stream_if.out_valid_o, 1'b0);
        check("rst_in_ready",  stream_if.in_ready_o,  1'b0);
        check("rst_ram_wen",   ram_wen,   1'b0);
        check("rst_ram_ren",   ram_ren,   1'b0);
        check("rst_level",     level,     '0);
        check("rst_out_data",  stream_if.out_data_o,  '0);
        check("ram_rce",       ram_rce,   1'b1);
        tick();
        tick();
        @(posedge user_clk);
        #3;
        reset_n = 1'b1;
        stream_if.in_valid_i  = 1'b0;
        stream_if.out_ready_i = 1'b0;
        tick();

        // Single word latency: write at T, read at T+1, visible from T+3.
        check("idle_ren", ram_ren, 1'b0);
        stream_if.in_valid_i  = 1'b1;
        stream_if.in_data_i   = DW'(8'hA5);
        stream_if.out_ready_i = 1'b1;
        tick();
        stream_if.in_valid_i = 1'b0;
        check("a5_level_t",  level, 1);
        check("a5_ren_t1",   ram_ren, 1'b1);
        tick();
        check("a5_level_t1", level, 0);
        check("a5_valid_t1", stream_if.out_valid_o, 1'b0);
        tick();
        check("a5_valid_t2", stream_if.out_valid_o, 1'b0);
        tick();
        check("a5_valid_t3", stream_if.out_valid_o, 1'b1);
        check("a5_data_t3",  stream_if.out_data_o, DW'(8'hA5));
        drain("a5_drain", 20);

        // Fill with the consumer stalled: buffer plus whole RAM, then full.
        accepted = 0;
        acc      = 1'b1;
        for (int i = 0; i < 3000 && acc; i++) begin
            cycle(1'b1, rand_word(), 1'b0, acc);
            if (acc) accepted++;
        end
        check("fill_accepted",  accepted, ENTRIES + OBUF_DEPTH);
        check("fill_level",     level, ENTRIES);
        check("fill_out_valid", stream_if.out_valid_o, 1'b1);
        for (int i = 0; i < 3; i++) begin
            stream_if.in_valid_i = 1'b1;
            #2;
            check("full_in_ready", stream_if.in_ready_o, 1'b0);
            check("full_no_wen",   ram_wen, 1'b0);
            tick();
        end
        stream_if.in_valid_i = 1'b0;
        drain("fill_drain", 3 * ENTRIES);

        // Streaming with both sides ready: in order and back to back.
        n_pop         = 0;
        first_pop_cyc = -1;
        sent          = 0;
        for (int i = 0; i < 10000 && sent < 5000; i++) begin
            cycle(1'b1, DW'(sent + 1), 1'b1, acc);
            if (acc) sent++;
        end
        stream_if.in_valid_i = 1'b0;
        drain("stream_drain", 100);
        check("stream_count", n_pop, 5000);
        check("stream_rate",  last_pop_cyc - first_pop_cyc, 4999);

        // Random valid/ready on both sides.
        sent = 0;
        for (int i = 0; i < 40000 && sent < 10000; i++) begin
            cycle($urandom_range(0, 9) < 6, rand_word(), $urandom_range(0, 9) < 5, acc);
            if (acc) sent++;
        end
        check("rand_sent", sent, 10000);
        stream_if.in_valid_i = 1'b0;
        drain("rand_drain", 3 * ENTRIES);

        // Flush one cycle after two reads are issued: both returns are stale.
        cycle(1'b1, DW'(8'h11), 1'b0, acc);
        cycle(1'b1, DW'(8'h22), 1'b0, acc);
        cycle(1'b0, '0, 1'b0, acc);
        check("pre_flush_level", level, 0);
        flush                 = 1'b1;
        stream_if.in_valid_i  = 1'b1;
        stream_if.in_data_i   = DW'(8'h33);
        stream_if.out_ready_i = 1'b1;
        #2;
        check("flush_cycle_ready", stream_if.in_ready_o, 1'b0);
        tick();
        flush                = 1'b0;
        stream_if.in_valid_i = 1'b0;
        for (int i = 0; i < 4; i++) begin
            check("post_flush_valid", stream_if.out_valid_o, 1'b0);
            check("post_flush_level", level, 0);
            tick();
        end
        cycle(1'b1, DW'(1), 1'b1, acc);
        stream_if.in_valid_i = 1'b0;
        seen = 1'b0;
        for (int i = 0; i < 10 && !seen; i++) begin
            if (stream_if.out_valid_o) seen = 1'b1;
            else tick();
        end
        check("flush_next_seen", seen, 1'b1);
        check("flush_next_data", stream_if.out_data_o, DW'(1));
        drain("flush_drain", 20);

        // Reset mid-operation with 10 words in RAM and 2 reads in flight.
        for (int i = 0; i < 16; i++) cycle(1'b1, DW'(32'h100 + i), 1'b0, acc);
        for (int i = 0; i < 6; i++)  cycle(1'b0, '0, 1'b0, acc);
        check("pre_rst_level", level, 12);
        cycle(1'b0, '0, 1'b1, acc);
        cycle(1'b0, '0, 1'b1, acc);
        cycle(1'b0, '0, 1'b0, acc);
        check("pre_rst_level2", level, 10);
        reset_n               = 1'b0;
        stream_if.in_valid_i  = 1'b1;
        stream_if.in_data_i   = DW'(8'h66);
        stream_if.out_ready_i = 1'b1;
        #1;
        check("mid_rst_out_valid", stream_if.out_valid_o, 1'b0);
        check("mid_rst_in_ready",  stream_if.in_ready_o,  1'b0);
        check("mid_rst_ram_wen",   ram_wen, 1'b0);
        check("mid_rst_ram_ren",   ram_ren, 1'b0);
        check("mid_rst_level",     level, '0);
        check("mid_rst_out_data",  stream_if.out_data_o, '0);
        tick();
        tick();
        #2;
        reset_n             = 1'b1;
        stream_if.in_data_i = DW'(8'h77);
        #1;
        check("release_in_ready", stream_if.in_ready_o, 1'b1);
        tick();
        stream_if.in_valid_i = 1'b0;
        drain("rst_drain", 20);
        check("rst_final_level", level, 0);

        check("final_model_empty", model_q.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
